// File: rtl/vga_frame_arbiter_if.sv
// Display/writer/frame-buffer bus bundle for vga_frame_arbiter.
// master: the environment (display path, pixel writer, frame-buffer RAM).
// slave : the arbiter itself.
//   disp_req/disp_addr      display read request and pixel address
//   disp_data/disp_valid    read data returned to the display path
//   wr_valid/wr_ready       writer pixel handshake, wr_addr/wr_data payload
//   wr_frame_done           writer has finished filling the back bank
//   mem_addr/mem_we/...     single-port frame-buffer, bank in mem_addr MSB
interface vga_frame_arbiter_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 16
) ();
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_frame_done;

    logic [ADDR_W:0]   mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output disp_req, disp_addr,
        output wr_valid, wr_addr, wr_data, wr_frame_done,
        output mem_rdata,
        input  disp_data, disp_valid, wr_ready,
        input  mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  disp_req, disp_addr,
        input  wr_valid, wr_addr, wr_data, wr_frame_done,
        input  mem_rdata,
        output disp_data, disp_valid, wr_ready,
        output mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_frame_arbiter.sv
// Double-buffered VGA frame-buffer arbiter.
// The display always wins the single memory port; the writer fills the back
// bank in the remaining cycles. Once the writer reports the back bank full,
// the banks swap at the next frame_start (vertical blanking), so no visible
// line ever mixes banks.
// Ports:
//   clk, reset   pixel clock, synchronous active-high reset
//   frame_start  one-cycle pulse at start of vertical blanking
//   bus          display / writer / memory bundle (slave side)
//   front_bank   bank currently shown
//   frame_cnt    completed swaps, wraps 255->0
//   err_oob      sticky: a write with address >= FRAME_WORDS was consumed
module vga_frame_arbiter #(
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FRAME_WORDS = 76800
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    vga_frame_arbiter_if.slave  bus,
    output logic                front_bank,
    output logic [7:0]          frame_cnt,
    output logic                err_oob
);

    localparam logic [ADDR_W:0] FRAME_LIMIT = (ADDR_W+1)'(FRAME_WORDS);

    typedef enum logic {
        WRITING   = 1'b0,
        DONE_WAIT = 1'b1
    } state_e;

    state_e state;
    logic   disp_valid_q;
    logic   wr_ready_c;
    logic   wr_fire_c;
    logic   wr_in_range_c;

    // Writer may only use the port when the display is idle and the back
    // bank is still being filled.
    assign wr_ready_c    = !reset && !bus.disp_req && (state == WRITING);
    assign wr_fire_c     = bus.wr_valid && wr_ready_c;
    assign wr_in_range_c = {1'b0, bus.wr_addr} < FRAME_LIMIT;

    // Memory port mux: display reads the front bank, writer targets the back.
    assign bus.wr_ready  = wr_ready_c;
    assign bus.mem_we    = wr_fire_c && wr_in_range_c;
    assign bus.mem_addr  = bus.disp_req ? {front_bank, bus.disp_addr}
                                        : {~front_bank, bus.wr_addr};
    assign bus.mem_wdata = DATA_W'(bus.wr_data);

    // Synchronous RAM returns data one cycle after the request.
    assign bus.disp_data  = DATA_W'(bus.mem_rdata);
    assign bus.disp_valid = disp_valid_q;

    // Swap FSM plus status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WRITING;
            front_bank   <= 1'b0;
            frame_cnt    <= 8'd0;
            err_oob      <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            disp_valid_q <= bus.disp_req;

            // Out-of-range pixels are consumed but never written.
            if (wr_fire_c && !wr_in_range_c) begin
                err_oob <= 1'b1;
            end

            case (state)
                WRITING: begin
                    // frame_start is ignored here, even when coincident.
                    if (bus.wr_frame_done) begin
                        state <= DONE_WAIT;
                    end
                end
                DONE_WAIT: begin
                    if (frame_start) begin
                        front_bank <= ~front_bank;
                        frame_cnt  <= frame_cnt + 8'd1;
                        state      <= WRITING;
                    end
                end
                default: state <= WRITING;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Scoreboard bench for vga_frame_arbiter: stimulus pushes the expected
// per-cycle response from a swap-count reference model; a monitor pops and
// compares before each rising edge.
module tb_vga_frame_arbiter;

    localparam int unsigned ADDR_W      = 17;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned FRAME_WORDS = 76800;

    logic       clk;
    logic       reset;
    logic       frame_start;
    logic       front_bank;
    logic [7:0] frame_cnt;
    logic       err_oob;

    vga_frame_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vga_frame_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_WORDS(FRAME_WORDS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .bus(bus),
        .front_bank(front_bank),
        .frame_cnt(frame_cnt),
        .err_oob(err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic              wr_ready;
        logic              mem_we;
        logic              addr_chk;
        logic [ADDR_W:0]   mem_addr;
        logic [DATA_W-1:0] mem_wdata;
        logic              disp_valid;
        logic [DATA_W-1:0] disp_data;
        logic              front_bank;
        logic [7:0]        frame_cnt;
        logic              err_oob;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: bank/count derive from the number of swaps since reset.
    int swaps   = 0;
    bit pending = 0;
    bit err_m   = 0;
    bit prev_dr = 0;

    task automatic check(input string name, input int c,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    task automatic drive_cycle(input bit rst, input bit fs, input bit dr,
                               input logic [ADDR_W-1:0] da, input bit wv,
                               input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input bit wfd);
        exp_t e;
        bit   fire;
        bit   inr;
        bit   fb;
        logic [DATA_W-1:0] rd;
        @(negedge clk);
        rd                = DATA_W'($urandom);
        reset             = rst;
        frame_start       = fs;
        bus.disp_req      = dr;
        bus.disp_addr     = da;
        bus.wr_valid      = wv;
        bus.wr_addr       = wa;
        bus.wr_data       = wd;
        bus.wr_frame_done = wfd;
        bus.mem_rdata     = rd;

        fb   = (swaps % 2) == 1;
        fire = wv && !rst && !dr && !pending;
        inr  = int'(wa) < int'(FRAME_WORDS);

        e.cyc        = cyc;
        e.wr_ready   = !rst && !dr && !pending;
        e.mem_we     = fire && inr;
        e.addr_chk   = dr || (fire && inr);
        e.mem_addr   = dr ? {fb, da} : {!fb, wa};
        e.mem_wdata  = wd;
        e.disp_valid = prev_dr;
        e.disp_data  = rd;
        e.front_bank = fb;
        e.frame_cnt  = 8'(swaps % 256);
        e.err_oob    = err_m;
        if (cyc > 0) sb.push_back(e);
        cyc++;

        if (rst) begin
            swaps = 0; pending = 0; err_m = 0; prev_dr = 0;
        end else begin
            prev_dr = dr;
            if (fire && !inr) err_m = 1;
            if (pending) begin
                if (fs) begin
                    swaps++;
                    pending = 0;
                end
            end else if (wfd) begin
                pending = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive_cycle(0, 0, 0, '0, 1, ADDR_W'(i), DATA_W'(i), 0);
    endtask

    // Monitor: compare DUT against the oldest expectation just before posedge.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("wr_ready",   e.cyc, 32'(bus.wr_ready),   32'(e.wr_ready));
            check("mem_we",     e.cyc, 32'(bus.mem_we),     32'(e.mem_we));
            if (e.addr_chk)
                check("mem_addr", e.cyc, 32'(bus.mem_addr), 32'(e.mem_addr));
            if (e.mem_we)
                check("mem_wdata", e.cyc, 32'(bus.mem_wdata), 32'(e.mem_wdata));
            check("disp_valid", e.cyc, 32'(bus.disp_valid), 32'(e.disp_valid));
            check("disp_data",  e.cyc, 32'(bus.disp_data),  32'(e.disp_data));
            check("front_bank", e.cyc, 32'(front_bank),     32'(e.front_bank));
            check("frame_cnt",  e.cyc, 32'(frame_cnt),      32'(e.frame_cnt));
            check("err_oob",    e.cyc, 32'(err_oob),        32'(e.err_oob));
        end
    end

    initial begin
        reset = 1'b1; frame_start = 1'b0;
        bus.disp_req = 1'b0; bus.disp_addr = '0; bus.wr_valid = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.wr_frame_done = 1'b0;
        bus.mem_rdata = '0;

        drive_cycle(1, 0, 0, '0, 1, '0, '0, 0);
        drive_cycle(1, 0, 0, '0, 1, '0, '0, 0);

        // Display collides with writer, then an uncontested write.
        drive_cycle(0, 0, 1, 17'd3, 1, 17'd9, 16'h1234, 0);
        drive_cycle(0, 0, 0, '0, 1, 17'd5, 16'hF800, 0);
        idle(2);

        // Write coincident with frame done, swap 10 cycles later.
        drive_cycle(0, 0, 0, '0, 1, 17'd7, 16'h07E0, 1);
        idle(9);
        drive_cycle(0, 1, 0, '0, 1, 17'd8, 16'h001F, 0);
        idle(1);
        check("swap_front", cyc, 32'(front_bank), 32'd1);
        check("swap_cnt",   cyc, 32'(frame_cnt),  32'd1);

        // frame_start without a finished back bank does nothing.
        drive_cycle(0, 1, 0, '0, 1, 17'd9, 16'h0001, 0);
        idle(1);
        check("noswap_front", cyc, 32'(front_bank), 32'd1);
        check("noswap_cnt",   cyc, 32'(frame_cnt),  32'd1);

        // Coincident done and frame_start: swap deferred to next frame_start.
        drive_cycle(1, 0, 0, '0, 0, '0, '0, 0);
        drive_cycle(0, 1, 0, '0, 1, 17'd2, 16'h0002, 1);
        idle(3);
        check("coinc_cnt", cyc, 32'(frame_cnt), 32'd0);
        drive_cycle(0, 1, 0, '0, 1, 17'd3, 16'h0003, 0);
        idle(1);
        check("coinc_swap_cnt",   cyc, 32'(frame_cnt),  32'd1);
        check("coinc_swap_front", cyc, 32'(front_bank), 32'd1);

        // Out-of-range write, then reset while a swap is pending.
        drive_cycle(0, 0, 0, '0, 1, 17'd76800, 16'hBEEF, 0);
        idle(3);
        check("oob_sticky", cyc, 32'(err_oob), 32'd1);
        drive_cycle(0, 0, 0, '0, 0, '0, '0, 1);
        idle(2);
        drive_cycle(1, 0, 0, '0, 1, '0, '0, 0);
        idle(2);
        check("rst_front", cyc, 32'(front_bank), 32'd0);
        check("rst_cnt",   cyc, 32'(frame_cnt),  32'd0);
        check("rst_err",   cyc, 32'(err_oob),    32'd0);

        // Enough swaps to wrap frame_cnt.
        for (int i = 0; i < 260; i++) begin
            drive_cycle(0, 0, 0, '0, 1, ADDR_W'(i), DATA_W'(i), 1);
            drive_cycle(0, 1, i[0], ADDR_W'(i), 1, ADDR_W'(i), DATA_W'(i), 0);
        end
        idle(1);
        check("wrap_cnt", cyc, 32'(frame_cnt), 32'd4);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit rst, fs, dr, wv, wfd;
            logic [ADDR_W-1:0] wa;
            rst = ($urandom_range(0, 199) == 0);
            fs  = ($urandom_range(0, 15) == 0);
            wfd = ($urandom_range(0, 15) == 0);
            dr  = ($urandom_range(0, 1) == 1);
            wv  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 29) == 0)
                wa = ADDR_W'($urandom_range(FRAME_WORDS, (1 << ADDR_W) - 1));
            else
                wa = ADDR_W'($urandom_range(0, FRAME_WORDS - 1));
            drive_cycle(rst, fs, dr, ADDR_W'($urandom), wv, wa,
                        DATA_W'($urandom), wfd);
        end

        idle(2);
        @(negedge clk);
        #4;
        check("sb_drained", cyc, 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_arbiter.md
VGA_FRAME_ARBITER -- requirements
Module: vga_frame_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, pixel address width within one bank.
REQ-002 SHALL have parameter DATA_W, default 16, RGB565 pixel width.
REQ-003 SHALL have parameter FRAME_WORDS, default 76800, valid pixels per bank (320x240).
REQ-004 SHALL have port clk  in  1  pixel clock (pclk domain); sole clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_start  in  1  one-cycle pulse at start of vertical blanking.
REQ-007 SHALL have port disp_req  in  1  display read request (DE-qualified).
REQ-008 SHALL have port disp_addr  in  ADDR_W  display read address.
REQ-009 SHALL have port disp_data  out  DATA_W  read data to display path.
REQ-010 SHALL have port disp_valid  out  1  disp_data valid.
REQ-011 SHALL have port wr_valid  in  1  writer has a pixel.
REQ-012 SHALL have port wr_ready  out  1  arbiter accepts pixel this cycle.
REQ-013 SHALL have port wr_addr  in  ADDR_W  writer pixel address.
REQ-014 SHALL have port wr_data  in  DATA_W  writer pixel data.
REQ-015 SHALL have port wr_frame_done  in  1  one-cycle pulse: back bank fully written.
REQ-016 SHALL have port mem_addr  out  ADDR_W+1  frame-buffer address; MSB = bank.
REQ-017 SHALL have port mem_we  out  1  frame-buffer write enable.
REQ-018 SHALL have port mem_wdata  out  DATA_W  frame-buffer write data.
REQ-019 SHALL have port mem_rdata  in  DATA_W  frame-buffer read data, 1-cycle synchronous read.
REQ-020 SHALL have port front_bank  out  1  bank currently displayed.
REQ-021 SHALL have port frame_cnt  out  8  completed swaps, wraps 255->0.
REQ-022 SHALL have port err_oob  out  1  sticky: write address >= FRAME_WORDS seen.

Function
REQ-023 SHALL give display strict priority: disp_req=1 -> mem_addr={front_bank,disp_addr}, mem_we=0, wr_ready=0.
REQ-024 SHALL assert wr_ready only when disp_req=0 and state=WRITING (combinational).
REQ-025 SHALL on wr_valid&wr_ready drive mem_addr={~front_bank,wr_addr}, mem_wdata=wr_data, mem_we=1 same cycle.
REQ-026 SHALL on accepted write with wr_addr>=FRAME_WORDS hold mem_we=0, consume the pixel, set err_oob.
REQ-027 SHALL drive mem_we=0 in every cycle without an accepted in-range write.
REQ-028 SHALL register disp_valid = disp_req delayed one cycle; disp_data = mem_rdata (combinational pass-through).
REQ-029 SHALL implement FSM WRITING, DONE_WAIT.
REQ-030 SHALL move WRITING->DONE_WAIT on wr_frame_done; wr_frame_done in DONE_WAIT ignored.
REQ-031 SHALL in DONE_WAIT on frame_start toggle front_bank, increment frame_cnt, return to WRITING, all in the same clock edge.
REQ-032 SHALL ignore frame_start in WRITING (no swap, no count).
REQ-033 SHALL on simultaneous wr_frame_done and frame_start in WRITING enter DONE_WAIT without swapping; swap waits for next frame_start.
REQ-034 SHALL not swap mid-line: swap only on frame_start, so a display line never mixes banks.
REQ-035 SHALL treat a write and wr_frame_done in the same cycle as: write completes to old back bank, then DONE_WAIT.

Reset
REQ-036 SHALL on reset=1 at a clk edge set state=WRITING, front_bank=0, frame_cnt=0, err_oob=0, disp_valid=0.
REQ-037 SHALL hold err_oob until reset; reset mid-frame abandons pending swap.
REQ-038 SHALL keep mem_we=0 and wr_ready=0 while reset=1.

Verification
REQ-039 SHALL verify: disp_req=1, wr_valid=1 same cycle -> wr_ready=0, mem_we=0, mem_addr MSB=0; disp_valid=1 next cycle.
REQ-040 SHALL verify: disp_req=0, wr_valid=1, wr_addr=5, wr_data=16'hF800 -> mem_we=1, mem_addr=18'h20005, mem_wdata=16'hF800.
REQ-041 SHALL verify: wr_frame_done then frame_start 10 cycles later -> front_bank 0->1, frame_cnt=1, wr_ready 0 between them.
REQ-042 SHALL verify: frame_start without prior wr_frame_done -> front_bank and frame_cnt unchanged.
REQ-043 SHALL verify: wr_frame_done and frame_start same cycle -> no swap; next frame_start -> swap, frame_cnt=1.
REQ-044 SHALL verify: accepted write wr_addr=76800 -> mem_we=0, err_oob=1 until reset; reset in DONE_WAIT -> front_bank=0, frame_cnt=0, state WRITING.
